uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side buffer directly downstream of the uart RX path. Captures every m_valid/m_data
//  word, which the UART cannot stall. Presents the words to the host as a first-word-fall-through
//  valid/ready stream. Reports fill level, almost-full, a sticky overflow flag and a
//  dropped-word count.
// PARAMETERS
//  BITS_PER_WORD  8   width of each received word (matches uart)
//  DEPTH          16  FIFO entries; must be a power of 2, >= 2
//  AFULL_LEVEL    12  almost_full asserts when level >= AFULL_LEVEL (1..DEPTH)
//  DROP_CNT_W     8   width of the saturating dropped-word counter
// PORTS
//  clk           in   1                    system clock, all logic on posedge
//  rstn          in   1                    async active-low reset
//  in_valid      in   1                    from uart m_valid; one-cycle pulse per word
//  in_data       in   BITS_PER_WORD        from uart m_data; sampled when in_valid=1
//  out_valid     out  1                    head word available
//  out_ready     in   1                    host accepts head word when out_valid&&out_ready
//  out_data      out  BITS_PER_WORD        head word; stable while out_valid&&!out_ready
//  level         out  $clog2(DEPTH)+1      current occupancy 0..DEPTH
//  almost_full   out  1                    level >= AFULL_LEVEL
//  overflow      out  1                    sticky: a word was dropped
//  overflow_clr  in   1                    one-cycle pulse; clears overflow and drop_count
//  drop_count    out  DROP_CNT_W           words dropped since reset/clear; saturates at all-ones
// BEHAVIOUR
//  - Reset (rstn=0, async):
//    - pointers=0, level=0, out_valid=0, almost_full=0, overflow=0, drop_count=0.
//    - out_data=0 (don't-care while out_valid=0).
//    - Storage contents are not reset.
//  - Pointers: wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits.
//    - Address = low bits; wrap is natural modulo DEPTH.
//    - empty when ptrs equal; full when MSBs differ and low bits equal.
//  - push = in_valid && (!full || pop); pop = out_valid && out_ready.
//  - Write: on push, mem[wr_ptr] <= in_data; wr_ptr++ at that edge.
//  - Read: FWFT.
//    - out_valid = !empty (registered state, no combinational path from in_valid).
//    - out_data = mem[rd_ptr].
//  - Latency: word written at edge N -> out_valid=1 and out_data valid after edge N (1 cycle).
//  - Pop: rd_ptr++ at the edge where pop=1. The next word is presented the following cycle,
//    so back-to-back pops are supported at full rate.
//  - level: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - Simultaneous push & pop when full: both occur, level stays DEPTH, no drop.
//  - Simultaneous push & pop when empty: cannot happen, since out_valid=0 means no pop.
//  - Drop: in_valid && full && !pop.
//    - The word is discarded and mem is untouched.
//    - overflow <= 1.
//    - drop_count++ unless all-ones.
//  - overflow_clr && drop in the same cycle: set wins, overflow=1 and drop_count=1.
//  - overflow_clr without drop: overflow=0, drop_count=0 next cycle.
//  - in_data is ignored when in_valid=0.
//  - out_ready has no effect while out_valid=0.
//  - Reset mid-operation: all buffered words are lost and the outputs return to reset values
//    immediately. A partially received UART frame is not this block's concern.
// STRUCTURE
//  - uart_pkg (shared) holds:
//    - BITS_PER_WORD default;
//    - typedef logic [BITS_PER_WORD-1:0] uart_word_t;
//    - the function clog2-based PTR_W helper.
//  - Sub-module uart_fifo_ram: DEPTH x BITS_PER_WORD storage.
//    - Synchronous write, asynchronous read, no reset.
//  - The top level holds pointers, level, flags and drop counter.
// TESTING
//  Bench: uart (CLOCKS_PER_PULSE=10) in tx->rx loopback, m_valid/m_data -> in_valid/in_data.
//  1. Reset, out_ready=0, send 0xA5 -> one cycle after m_valid:
//     out_valid=1, out_data=0xA5, level=1.
//  2. Send 0xA5,0x3C,0xF0 with out_ready=0, then hold out_ready=1 ->
//     pops 0xA5,0x3C,0xF0 on three consecutive cycles, then out_valid=0, level=0.
//  3. out_ready=0, inject 16 words 0x00..0x0F directly ->
//     level=16, almost_full from the 12th word.
//     17th word 0x55 -> overflow=1, drop_count=1, level=16.
//     Drain yields 0x00..0x0F, not 0x55.
//  4. Full FIFO, in_valid and out_ready high in the same cycle (data 0x77) ->
//     no drop, level stays 16, 0x77 emerges last.
//  5. Overflow set, pulse overflow_clr together with another drop ->
//     overflow=1, drop_count=1. Next clr alone -> overflow=0, drop_count=0.
//  6. Fill with 5 words, assert rstn=0 mid-stream ->
//     out_valid=0, level=0 immediately. After release, the next word 0xC3 appears as head.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default word width, word type and pointer-width helper
// used by the receive FIFO and its storage.
package uart_pkg;

  localparam int UART_BITS_PER_WORD = 8;

  typedef logic [UART_BITS_PER_WORD-1:0] uart_word_t;

  // Pointer width for a power-of-2 FIFO: address bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// FIFO storage: synchronous write, asynchronous read, contents never reset.
module uart_fifo_ram #(
  parameter int DEPTH         = 16,
  parameter int BITS_PER_WORD = 8
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [BITS_PER_WORD-1:0]   wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [BITS_PER_WORD-1:0]   rd_data
);

  logic [BITS_PER_WORD-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer behind the UART RX path; the UART cannot be stalled, so
// words arriving while full are dropped and counted.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int BITS_PER_WORD = UART_BITS_PER_WORD,
  parameter int DEPTH         = 16,
  parameter int AFULL_LEVEL   = 12,
  parameter int DROP_CNT_W    = 8,
  localparam int PTR_W        = ptr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic [BITS_PER_WORD-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BITS_PER_WORD-1:0] out_data,
  output logic [PTR_W-1:0]         level,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic [DROP_CNT_W-1:0]    drop_count
);

  localparam int AW = PTR_W - 1;

  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic                     empty;
  logic                     full;
  logic                     push;
  logic                     pop;
  logic                     drop;
  logic [BITS_PER_WORD-1:0] rd_word;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot in the same edge, so a full FIFO still accepts a word then.
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;

  uart_fifo_ram #(
    .DEPTH         (DEPTH),
    .BITS_PER_WORD (BITS_PER_WORD)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_word)
  );

  assign out_data    = out_valid ? rd_word : '0;
  assign almost_full = (level >= PTR_W'(AFULL_LEVEL));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + PTR_W'(1);
        2'b01:   level <= level - PTR_W'(1);
        default: level <= level;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins: the new drop is the first one counted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (overflow_clr)          drop_count <= DROP_CNT_W'(1);
      else if (drop_count != '1) drop_count <= drop_count + DROP_CNT_W'(1);
    end else if (overflow_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [4:0] level;
  logic       almost_full;
  logic       overflow;
  logic       overflow_clr = 1'b0;
  logic [7:0] drop_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  int         m_drops = 0;

  uart_rx_fifo #(
    .BITS_PER_WORD (8),
    .DEPTH         (DEPTH),
    .AFULL_LEVEL   (AFULL),
    .DROP_CNT_W    (8)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the model follows the buffer's rules at the edge.
  task automatic tick(input bit iv, input logic [7:0] d, input bit rdy, input bit clr);
    bit pop, drop;
    in_valid = iv; in_data = d; out_ready = rdy; overflow_clr = clr;
    @(posedge clk);
    pop  = (q.size() > 0) && rdy;
    drop = iv && (q.size() == DEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (iv && !drop) q.push_back(d);
    if (drop) begin
      m_ovf = 1'b1;
      m_drops = clr ? 1 : ((m_drops == 255) ? 255 : m_drops + 1);
    end else if (clr) begin
      m_ovf = 1'b0;
      m_drops = 0;
    end
    #1;
    in_valid = 1'b0; overflow_clr = 1'b0; out_ready = 1'b0;
    in_data = 8'($urandom);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b want 0", almost_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    rstn = 1'b1;
  endtask

  task automatic test_single();
    tick(1, 8'hA5, 0, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", out_data); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level: got %0d want 1", level); end
    tick(0, 8'h00, 1, 0);
    checks++; if (out_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL single_drain: got valid=%b level=%0d want 0/0", out_valid, level); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = 8'hA5; exp[1] = 8'h3C; exp[2] = 8'hF0;
    for (int i = 0; i < 3; i++) tick(1, exp[i], 0, 0);
    tick(0, 8'hFF, 0, 0);
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL b2b_level: got %0d want 3", level); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin errors++; $display("FAIL b2b_pop%0d: got valid=%b data=%h want 1/%h", i, out_valid, out_data, exp[i]); end
      tick(0, 8'h00, 1, 0);
    end
    checks++; if (out_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL b2b_empty: got valid=%b level=%0d want 0/0", out_valid, level); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      tick(1, 8'(i), 0, 0);
      checks++; if (almost_full !== ((i + 1) >= AFULL)) begin errors++; $display("FAIL ovf_afull%0d: got %b want %b", i, almost_full, ((i + 1) >= AFULL)); end
    end
    checks++; if (level !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_full: got level=%0d ovf=%b want 16/0", level, overflow); end
    tick(1, 8'h55, 0, 0);
    checks++; if (overflow !== 1'b1 || drop_count !== 8'd1 || level !== 5'd16) begin errors++; $display("FAIL ovf_drop: got ovf=%b cnt=%0d level=%0d want 1/1/16", overflow, drop_count, level); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (out_data !== 8'(i)) begin errors++; $display("FAIL ovf_drain%0d: got %h want %h", i, out_data, 8'(i)); end
      tick(0, 8'h00, 1, 0);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) tick(1, 8'h10 + 8'(i), 0, 0);
    tick(1, 8'h77, 1, 0);
    checks++; if (level !== 5'd16 || drop_count !== 8'd1) begin errors++; $display("FAIL fullpp_level: got level=%0d cnt=%0d want 16/1", level, drop_count); end
    for (int i = 1; i < DEPTH; i++) begin
      checks++; if (out_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL fullpp_drain%0d: got %h want %h", i, out_data, 8'h10 + 8'(i)); end
      tick(0, 8'h00, 1, 0);
    end
    checks++; if (out_data !== 8'h77 || level !== 5'd1) begin errors++; $display("FAIL fullpp_last: got %h level=%0d want 77/1", out_data, level); end
    tick(0, 8'h00, 1, 0);
  endtask

  task automatic test_clear();
    for (int i = 0; i < DEPTH; i++) tick(1, 8'(i * 3), 0, 0);
    tick(1, 8'h99, 0, 1);
    checks++; if (overflow !== 1'b1 || drop_count !== 8'd1) begin errors++; $display("FAIL clr_with_drop: got ovf=%b cnt=%0d want 1/1", overflow, drop_count); end
    tick(0, 8'h00, 0, 1);
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL clr_alone: got ovf=%b cnt=%0d want 0/0", overflow, drop_count); end
    for (int i = 0; i < 260; i++) tick(1, 8'hEE, 0, 0);
    checks++; if (drop_count !== 8'd255 || level !== 5'd16) begin errors++; $display("FAIL clr_saturate: got cnt=%0d level=%0d want 255/16", drop_count, level); end
    tick(0, 8'h00, 0, 1);
  endtask

  task automatic test_reset_mid();
    while (q.size() > 0) tick(0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) tick(1, 8'h40 + 8'(i), 0, 0);
    rstn = 1'b0;
    #1;
    q.delete(); m_ovf = 1'b0; m_drops = 0;
    checks++; if (out_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL midrst_immediate: got valid=%b level=%0d want 0/0", out_valid, level); end
    @(posedge clk);
    #1 rstn = 1'b1;
    tick(1, 8'hC3, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hC3 || level !== 5'd1) begin errors++; $display("FAIL midrst_head: got valid=%b data=%h level=%0d want 1/c3/1", out_valid, out_data, level); end
  endtask

  task automatic test_random();
    int rdy_pct;
    for (int c = 0; c < 1500; c++) begin
      rdy_pct = ((c / 150) % 2 == 0) ? 15 : 80;
      tick($urandom_range(99) < 55, 8'($urandom), $urandom_range(99) < rdy_pct, $urandom_range(99) < 3);
      checks++;
      if (out_valid !== (q.size() > 0) || level !== 5'(q.size()) ||
          almost_full !== (q.size() >= AFULL) || overflow !== m_ovf ||
          drop_count !== 8'(m_drops) || (q.size() > 0 && out_data !== q[0])) begin
        errors++;
        $display("FAIL rand_c%0d: got v=%b d=%h l=%0d af=%b o=%b n=%0d want v=%b d=%h l=%0d o=%b n=%0d",
                 c, out_valid, out_data, level, almost_full, overflow, drop_count,
                 q.size() > 0, (q.size() > 0) ? q[0] : 8'h00, q.size(), m_ovf, m_drops);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_clear();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
